// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: pops words from a show-ahead FIFO and
// serializes them as start, LSB-first data, optional parity and stop bits.
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  baud_tick,
  input  logic                  tx_abort,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic                  tx_aborted
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  localparam logic [3:0] LAST_BIT  = 4'(DATA_WIDTH - 1);
  localparam logic [1:0] LAST_STOP = 2'(STOP_BITS - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [3:0]            bit_count_q, bit_count_d;
  logic [1:0]            stop_count_q, stop_count_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic                  load;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_count_d  = bit_count_q;
    stop_count_d = stop_count_q;
    parity_d     = parity_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    load         = 1'b0;
    fifo_rd      = 1'b0;

    // Abort outranks a coincident tick, so nothing shifts and nothing pops.
    if (tx_abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      aborted_d = 1'b1;
    end else if (baud_tick) begin
      unique case (state_q)
        S_IDLE:   load = !fifo_empty && !tx_abort;
        S_START:  state_d = S_DATA;
        S_DATA: begin
          shift_d     = shift_q >> 1;
          bit_count_d = bit_count_q + 4'd1;
          if (bit_count_q == LAST_BIT) state_d = PARITY_EN ? S_PARITY : S_STOP;
        end
        S_PARITY: state_d = S_STOP;
        S_STOP: begin
          if (stop_count_q == LAST_STOP) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            load    = !fifo_empty;
          end else begin
            stop_count_d = stop_count_q + 2'd1;
          end
        end
        default:  state_d = S_IDLE;
      endcase
    end

    if (load) begin
      fifo_rd      = 1'b1;
      shift_d      = fifo_rdata;
      parity_d     = PARITY_ODD ? ~^fifo_rdata : ^fifo_rdata;
      bit_count_d  = 4'd0;
      stop_count_d = 2'd0;
      state_d      = S_START;
    end

    // The line level is registered from the state being entered.
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      bit_count_q  <= '0;
      stop_count_q <= '0;
      parity_q     <= 1'b0;
      tx_q         <= 1'b1;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_count_q  <= bit_count_d;
      stop_count_q <= stop_count_d;
      parity_q     <= parity_d;
      tx_q         <= tx_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign tx         = tx_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign tx_done    = done_q;
  assign tx_aborted = aborted_q;

endmodule
